bcd_display_encoder: RTL



---
 rtl/display_pkg.sv | 40 ++++
 rtl/bcd_display_encoder_if.sv | 29 ++
 rtl/seg7_encode.sv | 39 +++
 rtl/bcd_display_encoder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants for the BCD display encoder.
//   - 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}, active high, dp always 0
//   - converter state encoding
//   - sizing constants and the double-dabble nibble adjust helper
package display_pkg;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   localparam int BCD_DIGITS = 4;
   localparam int BIN_WIDTH  = 14;
   localparam int BCD_WIDTH  = 4 * BCD_DIGITS;
   localparam logic [BIN_WIDTH-1:0] MAX_VALUE = 14'd9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   // Shift-add-3 correction: a nibble of 5 or more would exceed 9 after doubling.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      if (nib >= 4'd5) begin
         return nib + 4'd3;
      end else begin
         return nib;
      end
   endfunction

endpackage

// File: rtl/bcd_display_encoder_if.sv
// bcd_display_encoder_if: value handshake plus digit outputs of the encoder.
//   in_valid/in_value/in_ready : binary value handshake (source -> encoder)
//   done                       : one-cycle pulse when new digits are presented
//   digit0..digit3             : segment words, units..thousands
// Modports: master = value source / display side, slave = encoder.
interface bcd_display_encoder_if
   import display_pkg::*;
#(
   parameter int WIDTH = 15
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BIN_WIDTH-1:0] in_value;
   logic                 done;
   logic [WIDTH-1:0]     digit0;
   logic [WIDTH-1:0]     digit1;
   logic [WIDTH-1:0]     digit2;
   logic [WIDTH-1:0]     digit3;

   modport master (
      output in_valid, in_value,
      input  in_ready, done, digit0, digit1, digit2, digit3
   );

   modport slave (
      input  in_valid, in_value,
      output in_ready, done, digit0, digit1, digit2, digit3
   );
endinterface

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to 7-segment pattern (active high).
//   bcd   in  4 : digit value 0..9
//   blank in  1 : show nothing
//   dash  in  1 : show a dash (takes priority over blank)
//   seg   out 8 : pattern {dp,g,f,e,d,c,b,a}
module seg7_encode
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dash,
   output logic [7:0] seg
);

   // Pattern lookup; non-decimal nibbles show a dash so they are visibly wrong.
   always_comb begin
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_encoder.sv
// bcd_display_encoder: 14-bit binary -> four 7-segment words via double-dabble.
//   clk   in : clock, rising edge
//   reset in : synchronous active-high reset
//   bus      : slave side of bcd_display_encoder_if (handshake, done, digit0..3)
// Parameters: WIDTH (digit word width, >= 8), SEG_ACTIVE_LOW (invert [7:0]),
// LZ_BLANK (blank leading zeros, units digit always shown).
// One conversion takes 15 clocks from accept to outputs; all four words update
// on the same edge so the display never shows a partially converted value.
module bcd_display_encoder
   import display_pkg::*;
#(
   parameter int WIDTH          = 15,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit LZ_BLANK       = 1'b1
)
(
   input logic                  clk,
   input logic                  reset,
   bcd_display_encoder_if.slave bus
);

   localparam logic [7:0]       POL_MASK   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [WIDTH-1:0] BLANK_WORD = WIDTH'(POL_MASK);

   state_t                                state_r;
   logic [3:0]                            cnt_r;
   // {BCD accumulator, binary shift register} shifted as one word
   logic [BCD_WIDTH+BIN_WIDTH-1:0]        work_r;
   logic                                  ovf_r;
   logic                                  in_ready_r;
   logic                                  done_r;
   logic [BCD_DIGITS-1:0][WIDTH-1:0]      digit_r;

   logic [BCD_WIDTH-1:0]                  bcd_s;
   logic [BCD_WIDTH-1:0]                  bcd_adj_s;
   logic [BCD_DIGITS-1:0]                 blank_s;
   logic [BCD_DIGITS-1:0][7:0]            seg_s;
   logic [BCD_DIGITS-1:0][WIDTH-1:0]      word_s;

   assign bcd_s = work_r[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];

   // Add-3 correction of every BCD nibble ahead of the next shift.
   always_comb begin
      bcd_adj_s = 16'd0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj_s[i*4 +: 4] = add3(bcd_s[i*4 +: 4]);
      end
   end

   // Leading-zero blanking cascades from the thousands digit downward.
   always_comb begin
      blank_s    = 4'b0000;
      blank_s[3] = (LZ_BLANK == 1'b1) && (bcd_s[15:12] == 4'd0);
      blank_s[2] = blank_s[3] && (bcd_s[11:8] == 4'd0);
      blank_s[1] = blank_s[2] && (bcd_s[7:4] == 4'd0);
      blank_s[0] = 1'b0;
   end

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
         .bcd   (bcd_s[g*4 +: 4]),
         .blank (blank_s[g]),
         .dash  (ovf_r),
         .seg   (seg_s[g])
      );
      assign word_s[g] = WIDTH'(seg_s[g] ^ POL_MASK);
   end

   // Converter FSM, shift/add-3 datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         work_r     <= 30'd0;
         ovf_r      <= 1'b0;
         in_ready_r <= 1'b0;
         done_r     <= 1'b0;
         digit_r    <= {BCD_DIGITS{BLANK_WORD}};
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.in_valid && in_ready_r) begin
                  work_r     <= {16'd0, bus.in_value};
                  cnt_r      <= 4'(BIN_WIDTH - 1);
                  ovf_r      <= (bus.in_value > MAX_VALUE);
                  in_ready_r <= 1'b0;
                  state_r    <= SHIFT;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            SHIFT: begin
               // Overflowed values still shift so every conversion has equal latency.
               work_r <= {bcd_adj_s, work_r[BIN_WIDTH-1:0]} << 5'd1;
               if (cnt_r == 4'd0) begin
                  state_r <= LOAD;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            LOAD: begin
               digit_r    <= word_s;
               done_r     <= 1'b1;
               in_ready_r <= 1'b1;
               state_r    <= IDLE;
            end
            default: begin
               state_r    <= IDLE;
               in_ready_r <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.done     = done_r;
   assign bus.digit0   = digit_r[0];
   assign bus.digit1   = digit_r[1];
   assign bus.digit2   = digit_r[2];
   assign bus.digit3   = digit_r[3];

endmodule
